memory_board_gen: RTL
=====================

# memory_board_gen

Parametrised board generator for the Memory Matrix game. On `start` it builds a ROWS×COLS board with exactly the requested number of lit tiles. Tile positions come from a free-running maximal-length LFSR, with duplicate and out-of-range positions rejected. The block then displays the board for a fixed number of cycles, hides it, and holds it for the play/compare logic until the round is acknowledged. It sits between the game controller (which supplies `start`, `num_lit` and `round_ack`) and the display and compare datapath.

## Interface
- ROWS, default 4: board rows.
- COLS, default 4: board columns. N = ROWS*COLS, IDX_W = clog2(N), N ≥ 2.
- LFSR_W, default 16: LFSR width. Must be 8, 16 or 32 and ≥ IDX_W.
- MAX_LIT, default 8: maximum lit tiles, ≤ N.
- SHOW_CYCLES, default 50_000_000: cycles the board is displayed, ≥ 1.
- SEED, default 16'hACE1: LFSR reset value. Zero is replaced by 1.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a round; sampled in IDLE only
- num_lit  in  clog2(MAX_LIT+1)  requested lit count; captured on start
- round_ack  in  1  PLAY→IDLE; ignored elsewhere
- board  out  N  tile map, bit r*COLS+c = tile (r,c)
- show  out  1  board is being displayed
- ready  out  1  board valid and hidden; play in progress
- busy  out  1  state is GEN or SHOW
- seed  in  LFSR_W  (only with MEMORY_BOARD_SEED_EN)
- seed_load  in  1  (only with MEMORY_BOARD_SEED_EN)

## Operation
- States: IDLE, GEN, SHOW, PLAY.
- LFSR: Fibonacci form, taps from the package. It advances every cycle in every state, so the cycle on which `start` arrives adds entropy.
- IDLE:
  - On start=1, go to GEN.
  - Clear board and the lit counter.
  - Set target = min(num_lit, MAX_LIT).
- GEN, one candidate per cycle:
  - Candidate idx = lfsr[IDX_W-1:0].
  - Accept if idx < N and board[idx] = 0: set the bit and increment the count.
  - Otherwise reject (no change).
  - When count reaches target, go to SHOW on the next edge.
  - target = 0 goes GEN→SHOW after one cycle with board = 0.
- SHOW: show=1 for exactly SHOW_CYCLES cycles, then go to PLAY.
- PLAY: ready=1 and board held. round_ack=1 goes to IDLE.
- IDLE keeps the last board and drives ready=0.
- start is ignored outside IDLE. round_ack is ignored outside PLAY.
- Termination: the LFSR is maximal-length and IDX_W ≤ LFSR_W, so every index recurs within 2^LFSR_W−1 cycles and GEN always completes.

## Timing
- Reset values: board=0, show=0, ready=0, busy=0, state IDLE, LFSR=SEED (or 1 if SEED=0), counters 0.
- Reset mid-round returns to these values on the next edge.
- start high at edge t: busy=1 and board=0 from t+1.
- Each accepted candidate appears on board one cycle later.
- The final accept at edge t gives show=1 from t+1 through t+SHOW_CYCLES, then ready=1 at t+SHOW_CYCLES+1.
- GEN latency is ≥ target cycles and is data-dependent.
- round_ack at edge t gives ready=0 at t+1. A start on that same edge is not seen; it must arrive while in IDLE.
- The SHOW counter is clog2(SHOW_CYCLES+1) bits and counts down; it never wraps.

## Configuration
- MEMORY_BOARD_SEED_EN defined:
  - The `seed` and `seed_load` ports exist.
  - seed_load=1 in any state loads the LFSR on the next edge; a zero seed becomes 1.
  - Reset has priority over seed_load.
- Undefined: the ports are absent and the LFSR is seeded only from SEED at reset.

## Structure
- Package memory_board_pkg holds:
  - the state enum;
  - the tap masks for LFSR widths 8, 16 and 32;
  - a clog2 helper.
- Sub-module lfsr_gen (parameters WIDTH and SEED; ports clk, reset, load, load_val, q) holds the LFSR.
- memory_board_gen contains the FSM, the candidate filter, the lit counter and the show counter.

## Test plan
- 4×4, SEED=16'hACE1, SHOW_CYCLES=8, num_lit=5:
  - popcount(board)=5 on entry to SHOW;
  - show high exactly 8 cycles, then ready=1;
  - board unchanged until round_ack.
- num_lit=0: one GEN cycle, board=0, SHOW of 8 cycles, then PLAY. num_lit=15 with MAX_LIT=8: popcount = 8.
- ROWS=3, COLS=3 (idx 9–15 invalid), num_lit=8: no out-of-range acceptance, board is 9 bits with 8 set, and the result matches a golden LFSR model cycle by cycle.
- Reset asserted during SHOW, then start again after the same number of cycles: outputs reset on the next edge, and the second board is identical to the first (determinism).
- start pulsed during GEN, SHOW and PLAY, and round_ack pulsed in GEN: no effect on state or board.
- MEMORY_BOARD_SEED_EN defined: seed_load with seed=0 makes the LFSR 1; seed_load with 16'h0001 gives a board matching the golden model for that seed.

Source files
------------

// File: rtl/memory_board_pkg.sv
// memory_board_pkg: shared FSM state type, LFSR tap masks and clog2 helper.
package memory_board_pkg;
  typedef enum logic [1:0] {IDLE, GEN, SHOW, PLAY} state_t;
  localparam logic [7:0] TAPS8 = 8'hB8;
  localparam logic [15:0] TAPS16 = 16'hB400;
  localparam logic [31:0] TAPS32 = 32'h8020_0003;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [31:0] taps(input int w);
    return w == 8 ? 32'(TAPS8) : w == 16 ? 32'(TAPS16) : TAPS32;
  endfunction
endpackage

// File: rtl/memory_board_gen_lfsr.sv
// lfsr_gen: free-running Fibonacci LFSR with synchronous seed load; zero seeds become 1.
module lfsr_gen
  import memory_board_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q
);
  localparam logic [WIDTH-1:0] TAPS = WIDTH'(taps(WIDTH));
  localparam logic [WIDTH-1:0] INIT = SEED == '0 ? WIDTH'(1) : SEED;
  always_ff @(posedge clk)
    if (reset) q <= INIT;
    else if (load) q <= load_val == '0 ? WIDTH'(1) : load_val;
    else q <= {q[WIDTH-2:0], ^(q & TAPS)};
endmodule

// File: rtl/memory_board_gen.sv
// memory_board_gen: builds a random ROWSxCOLS board with num_lit tiles, shows it, then holds it for play.
// Define MEMORY_BOARD_SEED_EN to add the runtime seed/seed_load ports.
module memory_board_gen
  import memory_board_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int LFSR_W = 16,
  parameter int MAX_LIT = 8,
  parameter int SHOW_CYCLES = 50_000_000,
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [clog2(MAX_LIT+1)-1:0]     num_lit,
  input  logic                            round_ack,
  output logic [ROWS*COLS-1:0]            board,
  output logic                            show,
  output logic                            ready,
  output logic                            busy
`ifdef MEMORY_BOARD_SEED_EN
  ,
  input  logic [LFSR_W-1:0]               seed,
  input  logic                            seed_load
`endif
);
  localparam int N = ROWS * COLS;
  localparam int IDX_W = clog2(N);
  localparam int LIT_W = clog2(MAX_LIT + 1);
  localparam int SC_W = clog2(SHOW_CYCLES + 1);
  state_t state;
  logic [LIT_W-1:0] cnt, target;
  logic [SC_W-1:0] sc;
  logic [LFSR_W-1:0] lfsr, ld_val;
  logic [IDX_W-1:0] idx;
  logic [N-1:0] mask;
  logic ld, accept, done, unused_lfsr;
`ifdef MEMORY_BOARD_SEED_EN
  assign ld = seed_load;
  assign ld_val = seed;
`else
  assign ld = 1'b0;
  assign ld_val = '0;
`endif
  lfsr_gen #(.WIDTH(LFSR_W), .SEED(SEED)) u_lfsr (
    .clk(clk), .reset(reset), .load(ld), .load_val(ld_val), .q(lfsr)
  );
  assign unused_lfsr = ^lfsr;
  assign idx = lfsr[IDX_W-1:0];
  assign mask = N'(1) << idx;
  // Out-of-range indices and already-lit tiles are rejected; GEN retries next cycle.
  assign accept = state == GEN && cnt != target && int'(idx) < N && (board & mask) == '0;
  assign done = cnt == target || (accept && cnt + LIT_W'(1) == target);
  assign show = state == SHOW;
  assign ready = state == PLAY;
  assign busy = state == GEN || state == SHOW;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      board <= '0;
      cnt <= '0;
      target <= '0;
      sc <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          state <= GEN;
          board <= '0;
          cnt <= '0;
          target <= num_lit > LIT_W'(MAX_LIT) ? LIT_W'(MAX_LIT) : num_lit;
        end
        GEN: begin
          if (accept) begin
            board <= board | mask;
            cnt <= cnt + LIT_W'(1);
          end
          if (done) begin
            state <= SHOW;
            sc <= SC_W'(SHOW_CYCLES - 1);
          end
        end
        SHOW: if (sc == '0) state <= PLAY;
              else sc <= sc - SC_W'(1);
        PLAY: if (round_ack) state <= IDLE;
      endcase
    end
endmodule
